chan_mux_reg: RTL and testbench

- Parametrised successor to the 2:1 MUX family: an N-channel, W-bit registered multiplexer with valid/ready handshakes on every input and on the output.
- Two select modes:
  - MODE=0: external select.
  - MODE=1: round-robin arbitration among requesting channels.
- Sits between multiple producers and a single consumer. Replaces ad-hoc MUX0..MUX3 chains where data must be held until accepted.

---
 rtl/chan_mux_reg.sv | 103 ++++++++++
 tb/tb_chan_mux_reg.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/chan_mux_reg.sv
// N-channel W-bit registered multiplexer with valid/ready handshakes.
// Channel choice is an external select (MODE=0) or round-robin arbitration (MODE=1).
module chan_mux_reg #(
    parameter int unsigned W    = 8,
    parameter int unsigned N    = 4,
    parameter int unsigned SELW = 2,
    parameter int unsigned MODE = 0
) (
    input  logic              c,
    input  logic              rst,
    input  logic [SELW-1:0]   sel,
    input  logic [N-1:0]      in_valid,
    input  logic [N*W-1:0]    in_data,
    output logic [N-1:0]      in_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [SELW-1:0]   out_ch,
    input  logic              out_ready
);

    logic            out_valid_q;
    logic [W-1:0]    out_data_q;
    logic [SELW-1:0] out_ch_q;
    logic [SELW-1:0] ptr_q;
    logic [SELW-1:0] ptr_d;

    logic            load;
    logic            grant;
    logic [SELW-1:0] gidx;
    logic [W-1:0]    data_mux;
    int unsigned     idx;

    assign load = ~out_valid_q | out_ready;

    always_comb begin
        grant = 1'b0;
        gidx  = '0;
        idx   = 0;
        if (MODE == 0) begin
            // sel >= N simply matches no channel, so no grant
            for (int unsigned k = 0; k < N; k++) begin
                if (32'(sel) == k) begin
                    grant = in_valid[k];
                    gidx  = SELW'(k);
                end
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                idx = 32'(ptr_q) + i;
                if (idx >= N) begin
                    idx = idx - N;
                end
                for (int unsigned k = 0; k < N; k++) begin
                    if (k == idx && !grant && in_valid[k]) begin
                        grant = 1'b1;
                        gidx  = SELW'(k);
                    end
                end
            end
        end
    end

    always_comb begin
        data_mux = '0;
        in_ready = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (SELW'(k) == gidx) begin
                data_mux    = in_data[k*W +: W];
                in_ready[k] = load & grant & ~rst;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (MODE == 1 && load && grant) begin
            ptr_d = (32'(gidx) == N - 1) ? '0 : gidx + SELW'(1);
        end
    end

    always_ff @(posedge c) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (load) begin
                out_valid_q <= grant;
                if (grant) begin
                    out_data_q <= data_mux;
                    out_ch_q   <= gidx;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_chan_mux_reg.sv
// Directed bench: external-select (N=4 and N=3) and round-robin instances of chan_mux_reg.
module tb_chan_mux_reg;

    logic c = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 c = ~c;

    // dut0: MODE=0, N=4
    logic [1:0]  sel0;
    logic [3:0]  iv0, ir0;
    logic [31:0] id0;
    logic        ov0, ordy0;
    logic [7:0]  od0;
    logic [1:0]  och0;

    // dut1: MODE=0, N=3
    logic [1:0]  sel1;
    logic [2:0]  iv1, ir1;
    logic [23:0] id1;
    logic        ov1, ordy1;
    logic [7:0]  od1;
    logic [1:0]  och1;

    // dut2: MODE=1, N=4
    logic [1:0]  sel2;
    logic [3:0]  iv2, ir2;
    logic [31:0] id2;
    logic        ov2, ordy2;
    logic [7:0]  od2;
    logic [1:0]  och2;

    chan_mux_reg #(.W(8), .N(4), .SELW(2), .MODE(0)) dut0 (
        .c(c), .rst(rst), .sel(sel0), .in_valid(iv0), .in_data(id0), .in_ready(ir0),
        .out_valid(ov0), .out_data(od0), .out_ch(och0), .out_ready(ordy0)
    );

    chan_mux_reg #(.W(8), .N(3), .SELW(2), .MODE(0)) dut1 (
        .c(c), .rst(rst), .sel(sel1), .in_valid(iv1), .in_data(id1), .in_ready(ir1),
        .out_valid(ov1), .out_data(od1), .out_ch(och1), .out_ready(ordy1)
    );

    chan_mux_reg #(.W(8), .N(4), .SELW(2), .MODE(1)) dut2 (
        .c(c), .rst(rst), .sel(sel2), .in_valid(iv2), .in_data(id2), .in_ready(ir2),
        .out_valid(ov2), .out_data(od2), .out_ch(och2), .out_ready(ordy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here
    task automatic tick();
        @(posedge c);
        #1;
    endtask

    task automatic chk_rr(input string tag, input logic [3:0] exp_rdy, input logic [1:0] ch);
        chk({tag, "_ready"}, 32'(ir2), 32'(exp_rdy));
        tick();
        chk({tag, "_valid"}, 32'(ov2), 32'd1);
        chk({tag, "_ch"}, 32'(och2), 32'(ch));
        chk({tag, "_data"}, 32'(od2), 32'(8'ha0 + 8'h11 * ch));
    endtask

    initial begin
        rst   = 1'b1;
        sel0  = 2'd2; iv0 = 4'b1111; id0 = {8'h44, 8'h33, 8'h22, 8'h11}; ordy0 = 1'b1;
        sel1  = 2'd0; iv1 = 3'b000;  id1 = {8'h77, 8'h66, 8'h55};        ordy1 = 1'b1;
        sel2  = 2'd0; iv2 = 4'b0000; id2 = {8'hd3, 8'hc2, 8'hb1, 8'ha0}; ordy2 = 1'b1;

        // Reset held for two edges with all channels offering
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_valid", 32'(ov0), 32'd0);
            chk("rst_data", 32'(od0), 32'd0);
            chk("rst_ch", 32'(och0), 32'd0);
            chk("rst_ready", 32'(ir0), 32'd0);
        end
        rst = 1'b0;
        #1;
        chk("first_ready", 32'(ir0), 32'b0100);
        tick();
        chk("first_valid", 32'(ov0), 32'd1);
        chk("first_data", 32'(od0), 32'h33);
        chk("first_ch", 32'(och0), 32'd2);

        // Backpressure on channel 1
        sel0 = 2'd1; iv0 = 4'b0010; id0 = {8'h44, 8'h33, 8'ha5, 8'h11};
        #1;
        chk("bp_load_ready", 32'(ir0), 32'b0010);
        tick();
        chk("bp_load_data", 32'(od0), 32'ha5);
        chk("bp_load_ch", 32'(och0), 32'd1);
        ordy0 = 1'b0;
        id0   = {8'h44, 8'h33, 8'h5a, 8'h11};
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_hold_ready", 32'(ir0), 32'd0);
            chk("bp_hold_data", 32'(od0), 32'ha5);
            chk("bp_hold_valid", 32'(ov0), 32'd1);
            tick();
        end
        chk("bp_hold_data_end", 32'(od0), 32'ha5);
        ordy0 = 1'b1; iv0 = 4'b0000;
        #1;
        chk("bp_drain_ready", 32'(ir0), 32'd0);
        tick();
        chk("bp_drain_valid", 32'(ov0), 32'd0);
        chk("bp_drain_data", 32'(od0), 32'ha5);

        // Out-of-range select on the 3-channel instance
        sel1 = 2'd3; iv1 = 3'b111;
        #1;
        chk("badsel_ready", 32'(ir1), 32'd0);
        tick();
        chk("badsel_valid", 32'(ov1), 32'd0);
        sel1 = 2'd2;
        #1;
        chk("sel2_ready", 32'(ir1), 32'b100);
        tick();
        chk("sel2_data", 32'(od1), 32'h77);

        // Round-robin, all channels requesting, consumer always ready
        iv2 = 4'b1111;
        #1;
        chk_rr("rr0", 4'b0001, 2'd0);
        chk_rr("rr1", 4'b0010, 2'd1);
        chk_rr("rr2", 4'b0100, 2'd2);
        chk_rr("rr3", 4'b1000, 2'd3);
        chk_rr("rr4", 4'b0001, 2'd0);
        chk_rr("rr5", 4'b0010, 2'd1);

        // Mid-stream reset: pointer is at 2 and a word is held
        rst = 1'b1;
        #1;
        chk("mrst_ready", 32'(ir2), 32'd0);
        tick();
        chk("mrst_valid", 32'(ov2), 32'd0);
        rst = 1'b0;
        #1;
        chk_rr("mrst_first", 4'b0001, 2'd0);

        // Skip and wrap: grant ch2 moves pointer to 3, then only ch0/ch1 request
        iv2 = 4'b0100;
        #1;
        chk_rr("sw_ch2", 4'b0100, 2'd2);
        iv2 = 4'b0011;
        #1;
        chk_rr("sw_wrap0", 4'b0001, 2'd0);
        chk_rr("sw_ch1", 4'b0010, 2'd1);
        chk_rr("sw_ch0", 4'b0001, 2'd0);

        iv2 = 4'b0000;
        #1;
        chk("rr_idle_ready", 32'(ir2), 32'd0);
        tick();
        chk("rr_idle_valid", 32'(ov2), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
